// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data cache memory arbiter.
// Request flags and FSM state encodings live here so every file agrees on them.
package mem_arbiter_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // 2'b11 is not a request; only a pure read or pure write counts
  function automatic logic rw_valid(input logic [1:0] flag);
    return (flag == RW_READ) || (flag == RW_WRITE);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant (icache vs dcache) with a last-grant register
// that only moves when the owning transaction completes.
module rr_arbiter2 #(
  parameter bit DCACHE_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req_ic,
  input  logic i_req_dc,
  input  logic i_update,
  input  logic i_upd_dc,
  output logic o_grant_dc
);

  logic r_last_dc;

  // Seeding last-grant with the other port makes the preferred port win the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_dc <= ~DCACHE_FIRST;
    end else if (i_update) begin
      r_last_dc <= i_upd_dc;
    end
  end

  assign o_grant_dc = i_req_dc & (~i_req_ic | ~r_last_dc);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache requests onto a single memory port.
// All outputs are registered; one transaction is in flight at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DCACHE_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ic_rw_flag,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [DATA_W-1:0] ic_write_data,
  input  logic [3:0]        ic_write_mask,
  output logic [DATA_W-1:0] ic_read_data,
  output logic              ic_busy,
  output logic              ic_done,
  input  logic [1:0]        dc_rw_flag,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_write_data,
  input  logic [3:0]        dc_write_mask,
  output logic [DATA_W-1:0] dc_read_data,
  output logic              dc_busy,
  output logic              dc_done,
  output logic [1:0]        mem_rw_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [3:0]        mem_write_mask,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_busy,
  input  logic              mem_done
);

  state_t r_state;
  state_t w_state_next;

  logic              r_gnt_dc;
  logic              r_is_read;
  logic [1:0]        r_mem_rw_flag;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_write_data;
  logic [3:0]        r_mem_write_mask;
  logic [DATA_W-1:0] r_ic_read_data;
  logic [DATA_W-1:0] r_dc_read_data;
  logic              r_ic_busy;
  logic              r_dc_busy;
  logic              r_ic_done;
  logic              r_dc_done;

  logic w_ic_req;
  logic w_dc_req;
  logic w_grant_dc;
  logic w_update;
  logic w_complete;
  logic w_start;

  assign w_ic_req = rw_valid(ic_rw_flag);
  assign w_dc_req = rw_valid(dc_rw_flag);
  assign w_start  = (r_state == ST_IDLE) && (w_ic_req || w_dc_req);
  assign w_update = (r_state == ST_RESP);

  rr_arbiter2 #(
    .DCACHE_FIRST (DCACHE_FIRST != 0)
  ) u_rr (
    .clk        (clk),
    .rst        (rst),
    .i_req_ic   (w_ic_req),
    .i_req_dc   (w_dc_req),
    .i_update   (w_update),
    .i_upd_dc   (r_gnt_dc),
    .o_grant_dc (w_grant_dc)
  );

  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_ic_req || w_dc_req) w_state_next = ST_ISSUE;
      ST_ISSUE: begin
        // Memory may accept and finish in the same cycle, skipping WAIT
        if (!mem_busy) begin
          w_complete   = mem_done;
          w_state_next = mem_done ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          w_complete   = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_gnt_dc         <= 1'b0;
      r_is_read        <= 1'b0;
      r_mem_rw_flag    <= RW_NONE;
      r_mem_addr       <= '0;
      r_mem_write_data <= '0;
      r_mem_write_mask <= '0;
      r_ic_read_data   <= '0;
      r_dc_read_data   <= '0;
      r_ic_busy        <= 1'b0;
      r_dc_busy        <= 1'b0;
      r_ic_done        <= 1'b0;
      r_dc_done        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // The mem_* registers double as the latched copy of the granted request
      if (w_start) begin
        r_gnt_dc         <= w_grant_dc;
        r_is_read        <= w_grant_dc ? (dc_rw_flag == RW_READ) : (ic_rw_flag == RW_READ);
        r_mem_rw_flag    <= w_grant_dc ? dc_rw_flag    : ic_rw_flag;
        r_mem_addr       <= w_grant_dc ? dc_addr       : ic_addr;
        r_mem_write_data <= w_grant_dc ? dc_write_data : ic_write_data;
        r_mem_write_mask <= w_grant_dc ? dc_write_mask : ic_write_mask;
        r_ic_busy        <= 1'b1;
        r_dc_busy        <= 1'b1;
      end
      if ((r_state == ST_ISSUE) && !mem_busy) begin
        r_mem_rw_flag <= RW_NONE;
      end
      if (w_complete) begin
        if (r_gnt_dc) begin
          r_dc_done <= 1'b1;
          r_dc_busy <= 1'b0;
          if (r_is_read) r_dc_read_data <= mem_read_data;
        end else begin
          r_ic_done <= 1'b1;
          r_ic_busy <= 1'b0;
          if (r_is_read) r_ic_read_data <= mem_read_data;
        end
      end
      if (r_state == ST_RESP) begin
        r_ic_done <= 1'b0;
        r_dc_done <= 1'b0;
        r_ic_busy <= 1'b0;
        r_dc_busy <= 1'b0;
      end
    end
  end

  assign ic_read_data   = r_ic_read_data;
  assign ic_busy        = r_ic_busy;
  assign ic_done        = r_ic_done;
  assign dc_read_data   = r_dc_read_data;
  assign dc_busy        = r_dc_busy;
  assign dc_done        = r_dc_done;
  assign mem_rw_flag    = r_mem_rw_flag;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_write_data;
  assign mem_write_mask = r_mem_write_mask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: cache-master drivers push expected read data,
// a monitor pops it on every done pulse, and a memory responder checks the bus.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ic_rw_flag = 2'b00, dc_rw_flag = 2'b00;
  logic [31:0] ic_addr = '0, dc_addr = '0, ic_write_data = '0, dc_write_data = '0;
  logic [3:0]  ic_write_mask = '0, dc_write_mask = '0;
  logic [31:0] ic_read_data, dc_read_data;
  logic        ic_busy, ic_done, dc_busy, dc_done;
  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read_data = '0;
  logic        mem_busy = 1'b0, mem_done = 1'b0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DCACHE_FIRST(1)) dut (
    .clk(clk), .rst(rst),
    .ic_rw_flag(ic_rw_flag), .ic_addr(ic_addr), .ic_write_data(ic_write_data),
    .ic_write_mask(ic_write_mask), .ic_read_data(ic_read_data), .ic_busy(ic_busy), .ic_done(ic_done),
    .dc_rw_flag(dc_rw_flag), .dc_addr(dc_addr), .dc_write_data(dc_write_data),
    .dc_write_mask(dc_write_mask), .dc_read_data(dc_read_data), .dc_busy(dc_busy), .dc_done(dc_done),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_read_data(mem_read_data), .mem_busy(mem_busy), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory contents: device side (responder) and reference side (scoreboard)
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  logic [31:0] ic_exp_q[$], dc_exp_q[$];
  logic [31:0] ic_last = '0, dc_last = '0;
  int          grant_log[$];

  // Memory responder configuration
  int cfg_busy = 0, cfg_wait = 0;
  bit cfg_rand = 0;

  // Memory responder: busy cycles while a request is presented, then accept,
  // then done after a number of wait cycles (0 = done in the accept cycle)
  initial begin
    bit          rsp_active = 0, pend = 0, hold_chk = 0;
    int          busy_left = 0, wait_left = 0, wcnt, port;
    logic [31:0] pend_data, rdata;
    logic [69:0] snap;
    forever begin
      @(negedge clk);
      mem_done      = 1'b0;
      mem_read_data = $urandom;
      if (hold_chk) check("mem_hold_while_busy", {mem_rw_flag, mem_addr, mem_write_data, mem_write_mask}, snap);
      hold_chk = 0;
      if (pend) begin
        if (wait_left <= 1) begin
          mem_done      = 1'b1;
          mem_read_data = pend_data;
          pend          = 0;
        end else wait_left--;
      end else if (mem_rw_flag != RW_NONE) begin
        if (!rsp_active) begin
          rsp_active = 1;
          busy_left  = cfg_rand ? int'($urandom_range(0, 3)) : cfg_busy;
        end
        if (busy_left > 0) begin
          busy_left--;
          mem_busy = 1'b1;
          hold_chk = 1;
          snap     = {mem_rw_flag, mem_addr, mem_write_data, mem_write_mask};
        end else begin
          mem_busy   = 1'b0;
          rsp_active = 0;
          port       = -1;
          if (dc_rw_flag == mem_rw_flag && dc_addr == mem_addr &&
              (mem_rw_flag == RW_READ || (dc_write_data == mem_write_data && dc_write_mask == mem_write_mask)))
            port = 1;
          else if (ic_rw_flag == mem_rw_flag && ic_addr == mem_addr &&
              (mem_rw_flag == RW_READ || (ic_write_data == mem_write_data && ic_write_mask == mem_write_mask)))
            port = 0;
          check("mem_req_matches_a_master", port >= 0, 1'b1);
          grant_log.push_back(port);
          if (mem_rw_flag == RW_WRITE) begin
            dev_mem[mem_addr] = merge(dev_rd(mem_addr), mem_write_data, mem_write_mask);
            rdata = $urandom;
          end else rdata = dev_rd(mem_addr);
          wcnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_wait;
          if (wcnt == 0) begin
            mem_done      = 1'b1;
            mem_read_data = rdata;
          end else begin
            pend      = 1;
            wait_left = wcnt;
            pend_data = rdata;
          end
        end
      end else mem_busy = 1'b0;
    end
  end

  // Monitor: pops the expected read_data on every done pulse
  initial begin
    logic ic_prev = 1'b0, dc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (ic_done) begin
          check("ic_done_one_cycle", ic_prev, 1'b0);
          check("ic_busy_during_done", ic_busy, 1'b0);
          if (ic_exp_q.size() == 0) check("ic_done_unexpected", ic_done, 1'b0);
          else check("ic_read_data", ic_read_data, ic_exp_q.pop_front());
        end
        if (dc_done) begin
          check("dc_done_one_cycle", dc_prev, 1'b0);
          check("dc_busy_during_done", dc_busy, 1'b0);
          if (dc_exp_q.size() == 0) check("dc_done_unexpected", dc_done, 1'b0);
          else check("dc_read_data", dc_read_data, dc_exp_q.pop_front());
        end
        if (mem_rw_flag != RW_NONE) check("busy_while_issuing", {ic_busy, dc_busy}, 2'b11);
      end
      ic_prev = ic_done;
      dc_prev = dc_done;
    end
  end

  task automatic drive(input int port, input logic [1:0] rw, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    if (port == 0) begin
      ic_rw_flag = rw; ic_addr = a; ic_write_data = d; ic_write_mask = m;
    end else begin
      dc_rw_flag = rw; dc_addr = a; dc_write_data = d; dc_write_mask = m;
    end
  endtask

  // One master transaction: push expectation, hold request until done, then drop it
  task automatic txn(input int port, input logic [1:0] rw, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, output int lat);
    logic [31:0] exp;
    int          t0;
    bit          got;
    @(negedge clk);
    if (rw == RW_READ) begin
      exp = ref_rd(a);
      if (port == 0) ic_last = exp; else dc_last = exp;
    end else begin
      ref_mem[a] = merge(ref_rd(a), d, m);
      exp = (port == 0) ? ic_last : dc_last;
    end
    if (port == 0) ic_exp_q.push_back(exp); else dc_exp_q.push_back(exp);
    drive(port, rw, a, d, m);
    t0  = cyc;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? ic_done : dc_done) got = 1;
    end
    check(port == 0 ? "ic_txn_completes" : "dc_txn_completes", got, 1'b1);
    lat = cyc - t0;
    drive(port, RW_NONE, a, d, m);
  endtask

  task automatic rand_master(input int port, input int n);
    int          lat, idle;
    logic [31:0] base;
    base = (port == 0) ? 32'h1000 : 32'h2000;
    for (int i = 0; i < n; i++) begin
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) begin
        @(negedge clk);
        drive(port, ($urandom_range(0, 1) == 1) ? 2'b11 : RW_NONE, $urandom, $urandom, 4'($urandom));
      end
      txn(port, ($urandom_range(0, 1) == 1) ? RW_WRITE : RW_READ,
          base + (32'($urandom_range(0, 15)) << 2), $urandom, 4'($urandom), lat);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_bus"}, {mem_rw_flag, mem_addr, mem_write_data, mem_write_mask}, '0);
    check({tag, "_ic_out"}, {ic_read_data, ic_busy, ic_done}, '0);
    check({tag, "_dc_out"}, {dc_read_data, dc_busy, dc_done}, '0);
  endtask

  initial begin
    int lat0, lat1;
    int exp_order[4];
    exp_order = '{1, 0, 1, 0};
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // rw_flag = 11 is not a request
    @(negedge clk);
    ic_rw_flag = 2'b11;
    repeat (10) begin
      @(negedge clk);
      check("rw11_no_mem_activity", mem_rw_flag, RW_NONE);
      check("rw11_not_busy", {ic_busy, dc_busy}, 2'b00);
    end
    ic_rw_flag = RW_NONE;

    // Ties: first goes to dcache, then alternate
    cfg_busy = 0; cfg_wait = 1;
    grant_log.delete();
    fork
      txn(0, RW_READ, 32'h0, 32'h0, 4'h0, lat0);
      txn(1, RW_WRITE, 32'h200, 32'h1234_5678, 4'hF, lat1);
    join
    fork
      txn(0, RW_READ, 32'h4, 32'h0, 4'h0, lat0);
      txn(1, RW_READ, 32'h200, 32'h0, 4'h0, lat1);
    join
    check("tie_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("tie_grant_order", grant_log[i], exp_order[i]);
    check("tie_dc_write_readback", dc_read_data, 32'h1234_5678);

    // Single dcache read with three busy cycles
    dev_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    cfg_busy = 3; cfg_wait = 2;
    grant_log.delete();
    txn(1, RW_READ, 32'h100, 32'h0, 4'h0, lat1);
    check("single_read_dc_data", dc_read_data, 32'hDEAD_BEEF);
    check("single_read_ic_untouched", ic_read_data, ic_last);
    check("single_read_one_grant", grant_log.size(), 1);

    // Back-to-back icache reads against zero-wait memory
    cfg_busy = 0; cfg_wait = 0;
    grant_log.delete();
    txn(0, RW_READ, 32'h0, 32'h0, 4'h0, lat0);
    check("b2b_first_latency", lat0, 2);
    txn(0, RW_READ, 32'h4, 32'h0, 4'h0, lat0);
    check("b2b_second_latency", lat0, 2);
    repeat (3) @(negedge clk);
    check("b2b_no_duplicate_grant", grant_log.size(), 2);

    // Write then read on the same port; scoreboard also checks read_data across the write
    cfg_busy = 1; cfg_wait = 1;
    txn(1, RW_WRITE, 32'h300, 32'hCAFE_F00D, 4'b0101, lat1);
    check("wr_keeps_read_data", dc_read_data, dc_last);
    txn(1, RW_READ, 32'h300, 32'h0, 4'h0, lat1);
    check("wr_then_rd_data", dc_read_data, merge(init_val(32'h300), 32'hCAFE_F00D, 4'b0101));

    // Randomized traffic from both masters
    cfg_rand = 1;
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join
    check("scoreboard_ic_drained", ic_exp_q.size(), 0);
    check("scoreboard_dc_drained", dc_exp_q.size(), 0);

    // Reset while waiting on memory; the late mem_done must be ignored
    cfg_rand = 0; cfg_busy = 0; cfg_wait = 6;
    @(negedge clk);
    drive(1, RW_READ, 32'h2040, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("rst_mid_in_wait", {mem_rw_flag, dc_busy}, {RW_NONE, 1'b1});
    rst = 1'b0;
    drive(1, RW_NONE, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("rst_mid_quiet", {ic_done, dc_done, ic_busy, dc_busy, mem_rw_flag}, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W default 32, address width; DATA_W default 32, data width; DCACHE_FIRST default 1, which port wins the first simultaneous request after reset.
REQ-002 SHALL have one clock; reset is synchronous and active-low. Ports: clk in 1, clock; rst in 1, synchronous active-low reset.
REQ-003 SHALL have the instruction-side ports: ic_rw_flag in 2 (01 read, 10 write); ic_addr in ADDR_W; ic_write_data in DATA_W; ic_write_mask in 4; ic_read_data out DATA_W; ic_busy out 1; ic_done out 1.
REQ-004 SHALL have the data-side ports dc_rw_flag, dc_addr, dc_write_data, dc_write_mask, dc_read_data, dc_busy and dc_done, with the same widths and meanings as REQ-003.
REQ-005 SHALL have the memory-side ports: mem_rw_flag out 2; mem_addr out ADDR_W; mem_write_data out DATA_W; mem_write_mask out 4; mem_read_data in DATA_W; mem_busy in 1; mem_done in 1.

Function
REQ-006 SHALL implement a registered FSM with states IDLE, ISSUE, WAIT and RESP; every output SHALL be a register.
REQ-007 A port request SHALL be valid when its rw_flag is 01 or 10; the value 11 SHALL be ignored and treated as no request.
REQ-008 IDLE, one valid request: grant that port and latch its rw_flag, addr, write_data and write_mask; next state ISSUE.
REQ-009 IDLE, both ports valid: grant by round-robin, with the port not granted last winning; the first tie after reset goes to dcache if DCACHE_FIRST=1.
REQ-010 ISSUE: drive mem_rw_flag, mem_addr, mem_write_data and mem_write_mask from the latched request.
REQ-011 ISSUE while mem_busy=1: hold all mem_* outputs stable.
REQ-012 ISSUE with mem_busy=0: memory accepts at that edge, mem_rw_flag goes to 00, and the FSM moves to WAIT, or straight to RESP if mem_done=1 in the same cycle.
REQ-013 WAIT: stay until mem_done=1; at that edge latch mem_read_data into the granted port's read_data (read requests only) and go to RESP.
REQ-014 RESP: assert the granted port's done for exactly one cycle; next state IDLE; update the last-grant pointer.
REQ-015 x_busy SHALL be 1 in every state except IDLE, for both ports; it SHALL be 0 in the cycle x_done is 1.
REQ-016 x_read_data SHALL hold its value until the next completed read on the same port; a write SHALL NOT alter it.
REQ-017 Masters SHALL drop rw_flag on the edge at which they sample done=1; the arbiter SHALL therefore not re-grant a stale request.
REQ-018 Minimum latency: request seen in cycle N gives mem_rw_flag in N+1; with zero-wait memory (mem_done in N+1), done is asserted in N+2.
REQ-019 A request changing while it is not granted SHALL be sampled only on the next IDLE; the granted transaction SHALL use latched values only.
REQ-020 mem_done outside ISSUE/WAIT SHALL be ignored.

Reset
REQ-021 rst=0 at a clock edge SHALL force IDLE, all outputs to 0 and the last-grant pointer to its initial value.
REQ-022 Reset mid-transaction SHALL abandon the transaction with no done pulse; a pending mem_done after reset SHALL be ignored by REQ-020.

Structure
REQ-023 The shared header SHALL hold RW_NONE=2'b00, RW_READ=2'b01, RW_WRITE=2'b10 and the FSM state encodings.
REQ-024 One sub-module SHALL exist: rr_arbiter2, a two-requester round-robin grant with a last-grant register and an update strobe driven in RESP.
REQ-025 The RTL SHALL total 120-400 lines.

Verification
REQ-026 Single read: dc read addr 0x100, memory returns 0xDEADBEEF after 3 busy cycles -> one dc_done pulse; dc_read_data=0xDEADBEEF; ic untouched.
REQ-027 Simultaneous requests, ic read 0x0 and dc write 0x200 data 0x12345678 mask 1111 -> dc served first, then ic, then the next tie goes to dc again.
REQ-028 Back-to-back ic reads 0x0 then 0x4 with zero-wait memory -> each done 2 cycles after request; one IDLE cycle between transactions; no duplicate grant.
REQ-029 rw_flag=11 on ic while dc idle -> no mem_rw_flag activity for 10 cycles; both busy outputs 0.
REQ-030 rst=0 while in WAIT, memory then asserts mem_done -> all outputs 0, no done pulse, FSM in IDLE.
REQ-031 A write followed by a read on the same port -> read_data is unchanged after the write and equals the memory value after the read.
